// File: rtl/shift_pkg.sv
// State encoding shared by the serial/shift blocks.
// Code 2'd3 is unused and recovers to FILL with the register cleared.
package shift_pkg;

   localparam logic [1:0] SHIFT_FILL_ENC  = 2'd0;
   localparam logic [1:0] SHIFT_FLUSH_ENC = 2'd1;
   localparam logic [1:0] SHIFT_FULL_ENC  = 2'd2;

   typedef enum logic [1:0] {
      ST_FILL  = SHIFT_FILL_ENC,
      ST_FLUSH = SHIFT_FLUSH_ENC,
      ST_FULL  = SHIFT_FULL_ENC
   } shift_state_e;

endpackage

// File: rtl/shift_reg_collect.sv
// Serial-to-parallel collector: LSB-first bits in, WIDTH-bit words out, with
// a flush that zero-pads a partial word so the received bits end up right-aligned.
//
// state | meaning
// FILL  | accepting serial bits, bit_ready=1
// FLUSH | shifting zeros in at the MSB until bit_count reaches WIDTH
// FULL  | word_out holds a complete word, waiting for word_ready
module shift_reg_collect
   import shift_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             bit_in,
   input  logic             bit_valid,
   output logic             bit_ready,
   input  logic             flush,
   output logic [WIDTH-1:0] word_out,
   output logic             word_valid,
   input  logic             word_ready,
   output logic             word_zero,
   output logic [CNT_W-1:0] bit_count
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   shift_state_e     state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_FILL;
         sreg_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_FILL: begin
            if (bit_valid) begin
               sreg_d = {bit_in, sreg_q[WIDTH-1:1]};
               cnt_d  = cnt_q + 1'b1;
            end
            // A bit that completes the word wins over a same-cycle flush.
            if (bit_valid && (cnt_q == CNT_LAST)) begin
               state_d = ST_FULL;
            end else if (flush && (cnt_d != '0)) begin
               state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = ST_FULL;
            end
         end
         ST_FULL: begin
            if (word_ready) begin
               state_d = ST_FILL;
               sreg_d  = '0;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_FILL;
            sreg_d  = '0;
            cnt_d   = '0;
         end
      endcase
   end

   assign bit_ready  = (state_q == ST_FILL);
   assign word_valid = (state_q == ST_FULL);
   assign word_out   = sreg_q;
   assign word_zero  = (sreg_q == '0);
   assign bit_count  = cnt_q;

endmodule

// File: tb/tb_shift_reg_collect.sv
// Directed checks on an 8-bit collector plus random streams on a 32-bit one.
module tb_shift_reg_collect;

   logic clk;
   logic reset_n;

   logic       bin8, bv8, fl8, wr8;
   logic       br8, wv8, wz8;
   logic [7:0] wo8;
   logic [3:0] bc8;

   logic        bin32, bv32, fl32, wr32;
   logic        br32, wv32, wz32;
   logic [31:0] wo32;
   logic [5:0]  bc32;

   int n_cmp = 0;
   int n_mis = 0;

   shift_reg_collect #(.WIDTH(8)) dut8 (
      .clk(clk), .reset_n(reset_n), .bit_in(bin8), .bit_valid(bv8), .bit_ready(br8),
      .flush(fl8), .word_out(wo8), .word_valid(wv8), .word_ready(wr8),
      .word_zero(wz8), .bit_count(bc8)
   );

   shift_reg_collect #(.WIDTH(32)) dut32 (
      .clk(clk), .reset_n(reset_n), .bit_in(bin32), .bit_valid(bv32), .bit_ready(br32),
      .flush(fl32), .word_out(wo32), .word_valid(wv32), .word_ready(wr32),
      .word_zero(wz32), .bit_count(bc32)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Streams n bits of w, LSB first, one per cycle; bit_valid dropped afterwards.
   task automatic send8(input logic [7:0] w, input int n);
      for (int i = 0; i < n; i++) begin
         bin8 = w[i];
         bv8  = 1'b1;
         tick();
      end
      bv8  = 1'b0;
      bin8 = 1'b0;
   endtask

   task automatic take8();
      wr8 = 1'b1;
      tick();
      wr8 = 1'b0;
   endtask

   initial begin
      int          n;
      int          idx;
      int          k;
      logic [31:0] w;
      logic [31:0] exp;

      reset_n = 1'b0;
      bin8 = 0; bv8 = 0; fl8 = 0; wr8 = 0;
      bin32 = 0; bv32 = 0; fl32 = 0; wr32 = 0;
      tick();
      tick();
      reset_n = 1'b1;

      chk("rst_wv", 32'(wv8), 32'd0);
      chk("rst_br", 32'(br8), 32'd1);
      chk("rst_wz", 32'(wz8), 32'd1);
      chk("rst_bc", 32'(bc8), 32'd0);

      // 1,0,1,1,0,0,1,0 LSB first -> 0x4D
      send8(8'h4D, 7);
      chk("t1_wv_7", 32'(wv8), 32'd0);
      chk("t1_bc_7", 32'(bc8), 32'd7);
      send8(8'h00, 0);
      bin8 = 1'b0; bv8 = 1'b1;
      tick();
      bv8 = 1'b0;
      chk("t1_wv", 32'(wv8), 32'd1);
      chk("t1_wo", 32'(wo8), 32'h4D);
      chk("t1_br", 32'(br8), 32'd0);
      chk("t1_bc", 32'(bc8), 32'd8);
      take8();
      chk("t1_br_after", 32'(br8), 32'd1);
      chk("t1_bc_after", 32'(bc8), 32'd0);
      chk("t1_wv_after", 32'(wv8), 32'd0);

      // 3 bits then flush -> 5 padding cycles
      send8(8'h07, 3);
      fl8 = 1'b1;
      tick();
      fl8 = 1'b0;
      chk("t2_br_flush", 32'(br8), 32'd0);
      chk("t2_bc_flush", 32'(bc8), 32'd3);
      n = 0;
      while (!wv8 && n < 20) begin
         bv8 = 1'b1; bin8 = 1'b1;
         tick();
         n++;
         if (!wv8) chk("t2_br_pad", 32'(br8), 32'd0);
      end
      bv8 = 1'b0; bin8 = 1'b0;
      chk("t2_cycles", 32'(n), 32'd5);
      chk("t2_wo", 32'(wo8), 32'h07);
      chk("t2_wv", 32'(wv8), 32'd1);
      take8();

      // flush with nothing held is ignored
      fl8 = 1'b1;
      tick();
      fl8 = 1'b0;
      chk("t3_br", 32'(br8), 32'd1);
      chk("t3_bc", 32'(bc8), 32'd0);
      chk("t3_wv", 32'(wv8), 32'd0);

      // flush together with the completing bit: no padding
      send8(8'hC3, 7);
      bin8 = 1'b1; bv8 = 1'b1; fl8 = 1'b1;
      tick();
      bv8 = 1'b0; fl8 = 1'b0; bin8 = 1'b0;
      chk("t3_full_wv", 32'(wv8), 32'd1);
      chk("t3_full_wo", 32'(wo8), 32'hC3);
      chk("t3_full_bc", 32'(bc8), 32'd8);
      tick();
      chk("t3_hold_wo", 32'(wo8), 32'hC3);
      take8();

      // full word held while bits keep arriving
      send8(8'hA5, 8);
      bv8 = 1'b1; bin8 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t4_wo_hold", 32'(wo8), 32'hA5);
      end
      chk("t4_bc", 32'(bc8), 32'd8);
      chk("t4_br", 32'(br8), 32'd0);
      bv8 = 1'b0; bin8 = 1'b0;
      take8();

      // word_ready outside FULL has no effect; then reset mid-word
      wr8 = 1'b1;
      send8(8'h1F, 5);
      wr8 = 1'b0;
      chk("t5_bc_mid", 32'(bc8), 32'd5);
      chk("t5_wz_mid", 32'(wz8), 32'd0);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      chk("t5_bc_rst", 32'(bc8), 32'd0);
      chk("t5_wv_rst", 32'(wv8), 32'd0);
      chk("t5_wz_rst", 32'(wz8), 32'd1);
      chk("t5_br_rst", 32'(br8), 32'd1);

      // reset mid-FLUSH
      send8(8'h03, 2);
      fl8 = 1'b1;
      tick();
      fl8 = 1'b0;
      tick();
      chk("t5_in_flush", 32'(br8), 32'd0);
      chk("t5_bc_flush", 32'(bc8), 32'd3);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      chk("t5_bc_rst2", 32'(bc8), 32'd0);
      chk("t5_wv_rst2", 32'(wv8), 32'd0);
      chk("t5_wz_rst2", 32'(wz8), 32'd1);
      tick();
      chk("t5_stay_fill", 32'(br8), 32'd1);

      // all-zero word
      send8(8'h00, 8);
      chk("t6_wv", 32'(wv8), 32'd1);
      chk("t6_wz", 32'(wz8), 32'd1);
      chk("t6_wo", 32'(wo8), 32'h00);
      take8();

      // 32-bit random streams with idle gaps; last one is partial + flush
      for (int t = 0; t < 5; t++) begin
         w   = $urandom;
         k   = (t >= 3) ? int'($urandom_range(1, 31)) : 32;
         exp = (k == 32) ? w : (w & ((32'd1 << k) - 32'd1));
         idx = 0;
         n   = 0;
         while (idx < k && n < 400) begin
            bv32 = ($urandom_range(0, 3) != 0);
            bin32 = bv32 ? w[idx] : 1'b0;
            tick();
            if (bv32) idx++;
            n++;
         end
         bv32 = 1'b0; bin32 = 1'b0;
         chk("r32_bits_sent", 32'(idx), 32'(k));
         if (k < 32) begin
            chk("r32_wv_early", 32'(wv32), 32'd0);
            chk("r32_bc_part", 32'(bc32), 32'(k));
            fl32 = 1'b1;
            tick();
            fl32 = 1'b0;
            n = 1;
            while (!wv32 && n < 60) begin
               tick();
               n++;
            end
            chk("r32_flush_cycles", 32'(n), 32'(32 - k + 1));
         end
         chk("r32_wv", 32'(wv32), 32'd1);
         chk("r32_wo", wo32, exp);
         chk("r32_wz", 32'(wz32), 32'(exp == 32'd0));
         chk("r32_bc", 32'(bc32), 32'd32);
         wr32 = 1'b1;
         tick();
         wr32 = 1'b0;
         chk("r32_br_after", 32'(br32), 32'd1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
